// File: rtl/spi_flash_read_seq.sv
// spi_flash_read_seq
//   Drives the Wishbone SPI byte engine to run SPI-flash READ transactions.
//   A request {addr_i, len_i} selects the flash, sends the read opcode and a
//   24-bit address, then clocks in len_i data bytes. The bytes come out as a
//   valid/ready stream. The flash is then deselected and done_o pulses once.
//   This block is the only Wishbone master of the SPI engine.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   req_i, addr_i, len_i    request; sampled only while idle
//   abort_i                 ends the current transaction early
//   busy_o, done_o          status; done_o is a one-cycle pulse per request
//   dout_o, dout_valid_o,   received byte stream; dout_valid_o is held
//   dout_ready_i            until the consumer takes the byte
//   m_*                     Wishbone master port to the SPI engine
module spi_flash_read_seq #(
  parameter int unsigned LEN_W  = 16,
  parameter logic [7:0]  RD_CMD = 8'h03,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             req_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic [15:0]      m_dat_o,
  input  logic [7:0]       m_dat_i,
  output logic             m_we_o,
  output logic [1:0]       m_sel_o,
  output logic             m_stb_o,
  output logic             m_cyc_o,
  input  logic             m_ack_i
);

  localparam logic [15:0] DAT_RESET = 16'h0300;
  localparam logic [1:0]  SEL_CS    = 2'b11;
  localparam logic [1:0]  SEL_BYTE  = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ZLEN,
    S_SEL,
    S_CMD,
    S_A2,
    S_A1,
    S_A0,
    S_DATA,
    S_HOLD,
    S_DESEL,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             stb_q;
  logic             abort_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] cnt_q;

  logic [15:0]      acc_dat_c;
  logic [1:0]       acc_sel_c;
  logic             abort_c;

  // stb, cyc and we all mark one access, so they come from one flop
  assign m_stb_o = stb_q;
  assign m_cyc_o = stb_q;
  assign m_we_o  = stb_q;

  // An abort seen this cycle counts the same as one recorded earlier
  assign abort_c = abort_q | abort_i;

  // Bus payload for the access that the current state issues
  always_comb begin
    acc_dat_c = {8'h00, FILL};
    acc_sel_c = SEL_BYTE;
    unique case (state_q)
      S_SEL: begin
        acc_dat_c = {6'b0, 1'b1, 1'b0, FILL};
        acc_sel_c = SEL_CS;
      end
      S_CMD: acc_dat_c = {8'h00, RD_CMD};
      S_A2:  acc_dat_c = {8'h00, addr_q[23:16]};
      S_A1:  acc_dat_c = {8'h00, addr_q[15:8]};
      S_A0:  acc_dat_c = {8'h00, addr_q[7:0]};
      S_DESEL: begin
        acc_dat_c = {6'b0, 1'b1, 1'b1, FILL};
        acc_sel_c = SEL_CS;
      end
      default: ;
    endcase
  end

  // Sequencer: state, bus handshake, count and stream outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      stb_q        <= 1'b0;
      abort_q      <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      dout_o       <= 8'h00;
      dout_valid_o <= 1'b0;
      m_dat_o      <= DAT_RESET;
      m_sel_o      <= 2'b00;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (req_i) begin
            busy_o  <= 1'b1;
            addr_q  <= addr_i;
            cnt_q   <= len_i;
            state_q <= (len_i == '0) ? S_ZLEN : S_SEL;
          end
        end

        // Zero-length request: one busy cycle, no bus traffic
        S_ZLEN: begin
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          state_q <= S_DONE;
        end

        // A new access is only issued while stb is low, so every access is
        // preceded by at least one idle stb cycle after the previous ack.
        S_SEL, S_CMD, S_A2, S_A1, S_A0, S_DATA: begin
          if (abort_i) begin
            abort_q <= 1'b1;
          end
          if (!stb_q) begin
            if (abort_c) begin
              state_q <= S_DESEL;
            end else begin
              stb_q   <= 1'b1;
              m_dat_o <= acc_dat_c;
              m_sel_o <= acc_sel_c;
            end
          end else if (m_ack_i) begin
            stb_q <= 1'b0;
            if (abort_c) begin
              // byte acked after abort is dropped
              state_q <= S_DESEL;
            end else begin
              unique case (state_q)
                S_SEL: state_q <= S_CMD;
                S_CMD: state_q <= S_A2;
                S_A2:  state_q <= S_A1;
                S_A1:  state_q <= S_A0;
                S_A0:  state_q <= S_DATA;
                default: begin
                  dout_o       <= m_dat_i;
                  dout_valid_o <= 1'b1;
                  cnt_q        <= cnt_q - LEN_W'(1);
                  state_q      <= S_HOLD;
                end
              endcase
            end
          end
        end

        // Flash stays selected with the SPI clock idle until the byte is taken
        S_HOLD: begin
          if (abort_c) begin
            abort_q      <= 1'b1;
            dout_valid_o <= 1'b0;
            state_q      <= S_DESEL;
          end else if (dout_ready_i) begin
            dout_valid_o <= 1'b0;
            state_q      <= (cnt_q != '0) ? S_DATA : S_DESEL;
          end
        end

        S_DESEL: begin
          if (!stb_q) begin
            stb_q   <= 1'b1;
            m_dat_o <= acc_dat_c;
            m_sel_o <= acc_sel_c;
          end else if (m_ack_i) begin
            stb_q   <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= S_DONE;
          end
        end

        // done_o is high during this cycle; new requests wait for IDLE
        S_DONE: begin
          abort_q <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
